instr_fetch: RTL and testbench

Instruction fetch unit that supplies the `instruction` word consumed by `mips_cpu`. It owns the program counter, reads a synchronous instruction memory and presents one instruction at a time under a valid/ready handshake. It computes the next PC from the branch/jump/jr outcome the CPU returns for the presented instruction. It sits between the instruction ROM and the CPU's decoder/control path.

---
 rtl/mips_pkg.sv | 20 ++
 rtl/next_pc_32.sv | 46 ++++
 rtl/instr_fetch.sv | 151 +++++++++++++++
 tb/tb_instr_fetch.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS fetch path: fetch FSM encoding, reset PC,
// ROM latency and the immediate sign-extension helper.
package mips_pkg;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    WAIT    = 2'd1,
    PRESENT = 2'd2
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Cycles from imem_req to valid imem_data.
  localparam logic [1:0] IMEM_LATENCY = 2'd1;

  function automatic logic [31:0] sign_extend_32(input logic [15:0] value);
    return {{16{value[15]}}, value};
  endfunction

endpackage

// File: rtl/next_pc_32.sv
// Combinational next-PC selection for the presented instruction.
// Priority: jr > jump > taken branch > sequential.
module next_pc_32
  import mips_pkg::*;
(
  input  logic [31:0] pc,
  input  logic        branch,
  input  logic        zero,
  input  logic        jump,
  input  logic [25:0] jump_target,
  input  logic [15:0] immediate,
  input  logic        jr,
  input  logic [31:0] jr_addr,
  output logic [31:0] next_pc,
  output logic        misaligned
);

  logic [31:0] pc_plus4_s;
  logic [31:0] offset_s;
  logic [31:0] branch_target_s;
  logic [31:0] jump_addr_s;
  logic [31:0] jr_target_s;

  assign pc_plus4_s      = pc + 32'd4;
  assign offset_s        = sign_extend_32(immediate);
  assign branch_target_s = pc_plus4_s + {offset_s[29:0], 2'b00};
  assign jump_addr_s     = {pc_plus4_s[31:28], jump_target, 2'b00};
  // Low bits are dropped so fetch always continues word-aligned.
  assign jr_target_s     = {jr_addr[31:2], 2'b00};
  assign misaligned      = jr & (jr_addr[1:0] != 2'b00);

  // Priority mux over the four next-PC sources.
  always_comb begin
    next_pc = pc_plus4_s;
    if (jr) begin
      next_pc = jr_target_s;
    end else if (jump) begin
      next_pc = jump_addr_s;
    end else if (branch && zero) begin
      next_pc = branch_target_s;
    end else begin
      next_pc = pc_plus4_s;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: owns the PC, reads the synchronous instruction ROM and
// presents one instruction at a time to the CPU under a valid/ready handshake.
module instr_fetch
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] instruction,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4,
  input  logic        branch,
  input  logic        zero,
  input  logic        jump,
  input  logic [25:0] jump_target,
  input  logic [15:0] immediate,
  input  logic        jr,
  input  logic [31:0] jr_addr,
  output logic        err_misaligned
);

  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  fetch_state_e state_r;
  fetch_state_e state_next_s;
  logic [31:0]  pc_r;
  logic [31:0]  next_pc_s;
  logic [31:0]  instruction_r;
  logic [31:0]  pc_out_r;
  logic         err_misaligned_r;
  logic [1:0]   rom_age_r;
  logic         rom_valid_s;
  logic         misaligned_s;
  logic         accept_s;
  logic         capture_s;
  logic         imem_req_s;
  logic [31:0]  imem_addr_s;
  logic         instr_valid_s;

  next_pc_32 u_next_pc (
    .pc          (pc_out_r),
    .branch      (branch),
    .zero        (zero),
    .jump        (jump),
    .jump_target (jump_target),
    .immediate   (immediate),
    .jr          (jr),
    .jr_addr     (jr_addr),
    .next_pc     (next_pc_s),
    .misaligned  (misaligned_s)
  );

  assign accept_s    = (state_r == PRESENT) && instr_ready;
  assign rom_valid_s = (rom_age_r == IMEM_LATENCY);
  assign capture_s   = (state_r == WAIT) && rom_valid_s;

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= FETCH;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      FETCH:   state_next_s = WAIT;
      WAIT:    state_next_s = rom_valid_s ? PRESENT : WAIT;
      PRESENT: state_next_s = instr_ready ? WAIT : PRESENT;
      default: state_next_s = FETCH;
    endcase
  end

  // FSM outputs; the refetch address follows next_pc in the accept cycle.
  always_comb begin
    imem_req_s    = 1'b0;
    imem_addr_s   = pc_r;
    instr_valid_s = 1'b0;
    case (state_r)
      FETCH: begin
        imem_req_s  = ~reset;
        imem_addr_s = pc_r;
      end
      WAIT: begin
        imem_req_s  = 1'b0;
        imem_addr_s = pc_r;
      end
      PRESENT: begin
        instr_valid_s = 1'b1;
        if (instr_ready) begin
          imem_req_s  = ~reset;
          imem_addr_s = next_pc_s;
        end else begin
          imem_req_s  = 1'b0;
          imem_addr_s = pc_r;
        end
      end
      default: begin
        imem_req_s    = 1'b0;
        imem_addr_s   = pc_r;
        instr_valid_s = 1'b0;
      end
    endcase
  end

  // PC, hold registers, ROM age tracker and sticky misalignment flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_r             <= RESET_PC_ALIGNED;
      instruction_r    <= 32'h0000_0000;
      pc_out_r         <= 32'h0000_0000;
      err_misaligned_r <= 1'b0;
      rom_age_r        <= 2'd0;
    end else begin
      if (accept_s) begin
        pc_r <= next_pc_s;
      end
      if (capture_s) begin
        instruction_r <= imem_data;
        pc_out_r      <= pc_r;
      end
      if (accept_s && misaligned_s) begin
        err_misaligned_r <= 1'b1;
      end
      // Counts cycles since the last request, saturating once data is stale.
      if (imem_req_s) begin
        rom_age_r <= 2'd1;
      end else if ((rom_age_r != 2'd0) && (rom_age_r != 2'd3)) begin
        rom_age_r <= rom_age_r + 2'd1;
      end
    end
  end

  assign imem_req       = imem_req_s;
  assign imem_addr      = imem_addr_s;
  assign instr_valid    = instr_valid_s;
  assign instruction    = instruction_r;
  assign pc_out         = pc_out_r;
  assign pc_plus4       = pc_out_r + 32'd4;
  assign err_misaligned = err_misaligned_r;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed test-plan scenarios with literal
// expectations, then randomized traffic compared every cycle against a reference model.
module tb_instr_fetch;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_data = 32'h0000_0000;
  logic [31:0] instruction;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  logic        branch = 1'b0;
  logic        zero = 1'b0;
  logic        jump = 1'b0;
  logic [25:0] jump_target = 26'd0;
  logic [15:0] immediate = 16'd0;
  logic        jr = 1'b0;
  logic [31:0] jr_addr = 32'd0;
  logic        err_misaligned;

  instr_fetch #(.RESET_PC(RST_PC)) dut (
    .clock          (clock),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .instruction    (instruction),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .pc_out         (pc_out),
    .pc_plus4       (pc_plus4),
    .branch         (branch),
    .zero           (zero),
    .jump           (jump),
    .jump_target    (jump_target),
    .immediate      (immediate),
    .jr             (jr),
    .jr_addr        (jr_addr),
    .err_misaligned (err_misaligned)
  );

  always #5 clock = ~clock;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // ROM contents as a pure function of the address; word 0 is the test-plan value.
  function automatic logic [31:0] rom_fn(input logic [31:0] a);
    if (a == 32'h0000_0000) return 32'h2008_0005;
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_1234;
  endfunction

  // Next PC straight from the architectural rules.
  function automatic logic [31:0] model_next(input logic [31:0] pc, input logic br, input logic z,
                                             input logic jp, input logic [25:0] jt,
                                             input logic [15:0] imm, input logic j_r,
                                             input logic [31:0] jra);
    logic [31:0] seq;
    int          off;
    seq = pc + 32'd4;
    off = int'($signed(imm));
    if (j_r) return jra & 32'hFFFF_FFFC;
    if (jp) return (seq & 32'hF000_0000) | (32'(jt) * 32'd4);
    if (br && z) return seq + 32'(off * 4);
    return seq;
  endfunction

  // ROM with one cycle of latency; unrequested cycles return junk.
  always @(posedge clock) begin
    if (imem_req) imem_data <= rom_fn(imem_addr);
    else imem_data <= $urandom;
  end

  // Reference model: pending fetch, presented instruction, sticky error.
  logic        m_init = 1'b0;
  logic        m_first = 1'b0;
  logic        m_valid = 1'b0;
  logic        m_pend = 1'b0;
  logic [31:0] m_pend_pc = 32'd0;
  logic [31:0] m_pc = 32'd0;
  logic [31:0] m_instr = 32'd0;
  logic        m_err = 1'b0;
  logic        e_req;
  logic [31:0] e_addr;

  always @(posedge clock) begin
    if (reset) begin
      m_init  <= 1'b1;
      m_first <= 1'b1;
      m_valid <= 1'b0;
      m_pend  <= 1'b0;
      m_pc    <= 32'd0;
      m_instr <= 32'd0;
      m_err   <= 1'b0;
    end else if (m_init) begin
      m_first <= 1'b0;
      if (m_pend) begin
        m_valid <= 1'b1;
        m_pc    <= m_pend_pc;
        m_instr <= rom_fn(m_pend_pc);
        m_pend  <= 1'b0;
      end else if (m_valid && instr_ready) begin
        m_valid <= 1'b0;
        if (jr && (jr_addr[1:0] != 2'b00)) m_err <= 1'b1;
      end
      if (m_first) begin
        m_pend    <= 1'b1;
        m_pend_pc <= RST_PC;
      end else if (m_valid && instr_ready) begin
        m_pend    <= 1'b1;
        m_pend_pc <= model_next(m_pc, branch, zero, jump, jump_target, immediate, jr, jr_addr);
      end
    end
  end

  // Compare process: every cycle after the first reset edge.
  always @(negedge clock) begin
    if (m_init) begin
      e_req  = !reset && (m_first || (m_valid && instr_ready));
      e_addr = m_first ? RST_PC
                       : model_next(m_pc, branch, zero, jump, jump_target, immediate, jr, jr_addr);
      check32("m_instr_valid", {31'd0, instr_valid}, {31'd0, m_valid});
      check32("m_imem_req", {31'd0, imem_req}, {31'd0, e_req});
      check32("m_err_misaligned", {31'd0, err_misaligned}, {31'd0, m_err});
      if (e_req) check32("m_imem_addr", imem_addr, e_addr);
      if (m_valid) begin
        check32("m_instruction", instruction, m_instr);
        check32("m_pc_out", pc_out, m_pc);
        check32("m_pc_plus4", pc_plus4, m_pc + 32'd4);
      end
    end
  end

  task automatic set_ctl(input logic rdy, input logic br, input logic z, input logic jp,
                         input logic [25:0] jt, input logic [15:0] imm, input logic j_r,
                         input logic [31:0] jra);
    instr_ready = rdy;
    branch      = br;
    zero        = z;
    jump        = jp;
    jump_target = jt;
    immediate   = imm;
    jr          = j_r;
    jr_addr     = jra;
  endtask

  // Called in a PRESENT cycle: accept with the given controls, check the next pc_out.
  task automatic go(input string name, input logic br, input logic z, input logic jp,
                    input logic [25:0] jt, input logic [15:0] imm, input logic j_r,
                    input logic [31:0] jra, input logic [31:0] exp_pc);
    set_ctl(1'b1, br, z, jp, jt, imm, j_r, jra);
    @(posedge clock); #1;
    set_ctl(1'b1, 1'b0, 1'b0, 1'b0, 26'd0, 16'd0, 1'b0, 32'd0);
    @(posedge clock);
    @(negedge clock);
    check32(name, pc_out, exp_pc);
    check32({name, "_valid"}, {31'd0, instr_valid}, 32'd1);
    #1;
  endtask

  initial begin
    set_ctl(1'b1, 1'b0, 1'b0, 1'b0, 26'd0, 16'd0, 1'b0, 32'd0);
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    // Cycle 0: fetch of RESET_PC.
    @(negedge clock);
    check32("fetch0_req", {31'd0, imem_req}, 32'd1);
    check32("fetch0_addr", imem_addr, 32'h0000_0000);
    repeat (2) @(posedge clock);
    @(negedge clock);
    check32("first_valid", {31'd0, instr_valid}, 32'd1);
    check32("first_instr", instruction, 32'h2008_0005);
    check32("first_pc", pc_out, 32'h0000_0000);
    check32("first_pc4", pc_plus4, 32'h0000_0004);

    // Sequential stream, one instruction every two cycles.
    for (int i = 1; i <= 3; i++) begin
      repeat (2) @(posedge clock);
      @(negedge clock);
      check32("seq_pc", pc_out, 32'(i * 4));
    end

    // Stall at pc 0x10 for five cycles.
    @(posedge clock); #1;
    instr_ready = 1'b0;
    @(posedge clock); #1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      check32("stall_pc", pc_out, 32'h0000_0010);
      check32("stall_instr", instruction, rom_fn(32'h0000_0010));
      check32("stall_req", {31'd0, imem_req}, 32'd0);
      check32("stall_valid", {31'd0, instr_valid}, 32'd1);
    end
    #1;

    // Control-flow cases.
    go("branch_taken", 1'b1, 1'b1, 1'b0, 26'd0, 16'hFFFC, 1'b0, 32'd0, 32'h0000_0004);
    go("jr_to_10", 1'b0, 1'b0, 1'b0, 26'd0, 16'd0, 1'b1, 32'h0000_0010, 32'h0000_0010);
    go("branch_not_taken", 1'b1, 1'b0, 1'b0, 26'd0, 16'hFFFC, 1'b0, 32'd0, 32'h0000_0014);
    go("jr_to_hi", 1'b0, 1'b0, 1'b0, 26'd0, 16'd0, 1'b1, 32'h1000_0040, 32'h1000_0040);
    go("jump", 1'b0, 1'b0, 1'b1, 26'h000_0100, 16'd0, 1'b0, 32'd0, 32'h1000_0400);
    go("jr_over_jump", 1'b0, 1'b0, 1'b1, 26'h3FF_FFFF, 16'd0, 1'b1, 32'h0000_0023, 32'h0000_0020);
    check32("err_set", {31'd0, err_misaligned}, 32'd1);
    check32("jr_pc4", pc_plus4, 32'h0000_0024);
    go("seq_after_err", 1'b0, 1'b0, 1'b0, 26'd0, 16'd0, 1'b0, 32'd0, 32'h0000_0024);
    check32("err_sticky", {31'd0, err_misaligned}, 32'd1);

    // Reset during WAIT.
    set_ctl(1'b1, 1'b0, 1'b0, 1'b0, 26'd0, 16'd0, 1'b0, 32'd0);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check32("rst_valid", {31'd0, instr_valid}, 32'd0);
    check32("rst_err", {31'd0, err_misaligned}, 32'd0);
    check32("rst_req", {31'd0, imem_req}, 32'd1);
    check32("rst_addr", imem_addr, RST_PC);
    repeat (2) @(posedge clock);
    @(negedge clock);
    check32("refetch_pc", pc_out, RST_PC);
    check32("refetch_instr", instruction, 32'h2008_0005);

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 600; c++) begin
      logic [31:0] jra;
      @(posedge clock); #1;
      reset = ($urandom_range(0, 59) == 0);
      jra = $urandom;
      if ($urandom_range(0, 3) != 0) jra[1:0] = 2'b00;
      set_ctl($urandom_range(0, 9) < 7,
              $urandom_range(0, 9) < 3,
              $urandom_range(0, 1) == 1,
              $urandom_range(0, 9) < 2,
              26'($urandom),
              16'($urandom),
              $urandom_range(0, 9) == 0,
              jra);
    end
    @(posedge clock); #1;
    reset = 1'b0;
    repeat (6) @(posedge clock);
    @(negedge clock); #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
